// File: rtl/decode_stage.sv
// MIPS instruction-decode / register-read stage feeding the ID/EX pipeline register.
// Decodes fields, bypasses write-back data, and inserts one bubble on load-use hazards.
module decode_stage (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Instr,
  input  logic [31:0] InPC,
  input  logic        Flush,
  output logic [4:0]  Rn1,
  output logic [4:0]  Rn2,
  input  logic [31:0] Out1,
  input  logic [31:0] Out2,
  input  logic        WbWrite,
  input  logic [4:0]  WbWn,
  input  logic [31:0] WbWd,
  output logic        OutValid,
  input  logic        ExReady,
  output logic [31:0] OutA,
  output logic [31:0] OutB,
  output logic [31:0] OutImm,
  output logic [4:0]  OutWn,
  output logic [5:0]  OutOp,
  output logic [5:0]  OutFunct,
  output logic        OutLoad,
  output logic        OutIllegal,
  output logic [31:0] OutPC,
  output logic [15:0] StallCount
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic        illegal, uses_rt, hazard, transfer;
  logic [4:0]  dec_wn;
  logic [31:0] dec_imm, dec_a, dec_b;

  assign op  = Instr[31:26];
  assign rs  = Instr[25:21];
  assign rt  = Instr[20:16];
  assign rd  = Instr[15:11];
  assign Rn1 = rs;
  assign Rn2 = rt;

  always_comb begin
    illegal = 1'b0;
    uses_rt = 1'b0;
    dec_wn  = 5'd0;
    dec_imm = {{16{Instr[15]}}, Instr[15:0]};
    case (op)
      OP_RTYPE: begin
        dec_wn  = rd;
        uses_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_LW: dec_wn = rt;
      OP_ANDI, OP_ORI: begin
        dec_wn  = rt;
        dec_imm = {16'd0, Instr[15:0]};
      end
      OP_SW, OP_BEQ: uses_rt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // Register 0 is hard-wired to zero; rs/rt != 0 also covers the WbWn != 0 bypass guard.
  always_comb begin
    dec_a = Out1;
    dec_b = Out2;
    if (rs == 5'd0)                        dec_a = 32'd0;
    else if (WbWrite && (WbWn == rs))      dec_a = WbWd;
    if (rt == 5'd0)                        dec_b = 32'd0;
    else if (WbWrite && (WbWn == rt))      dec_b = WbWd;
  end

  assign hazard = InValid && OutValid && OutLoad && (OutWn != 5'd0) &&
                  ((OutWn == rs) || ((OutWn == rt) && uses_rt));

  // Handshake: an instruction moves on an edge where its valid and the receiver's
  // ready are both high; the ID/EX slot frees when empty or when execute takes it.
  assign InReady  = (!OutValid || ExReady) && !hazard;
  assign transfer = InValid && InReady && !Flush;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      OutValid   <= 1'b0;
      OutA       <= 32'd0;
      OutB       <= 32'd0;
      OutImm     <= 32'd0;
      OutWn      <= 5'd0;
      OutOp      <= 6'd0;
      OutFunct   <= 6'd0;
      OutLoad    <= 1'b0;
      OutIllegal <= 1'b0;
      OutPC      <= 32'd0;
      StallCount <= 16'd0;
    end else begin
      if (hazard && (StallCount != 16'hFFFF))
        StallCount <= StallCount + 16'd1;
      if (Flush) begin
        OutValid <= 1'b0;
      end else if (transfer) begin
        OutValid   <= 1'b1;
        OutA       <= dec_a;
        OutB       <= dec_b;
        OutImm     <= dec_imm;
        OutWn      <= dec_wn;
        OutOp      <= op;
        OutFunct   <= Instr[5:0];
        OutLoad    <= (op == OP_LW);
        OutIllegal <= illegal;
        OutPC      <= InPC;
      end else if (ExReady || !OutValid) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for single-instruction decode plus
// hand-written sequences for load-use stall, hold, flush and reset.
module tb_decode_stage;

  logic        Clock, Resetn, InValid, InReady, Flush, ExReady;
  logic [31:0] Instr, InPC, Out1, Out2, WbWd;
  logic [4:0]  Rn1, Rn2, WbWn;
  logic        WbWrite;
  logic        OutValid, OutLoad, OutIllegal;
  logic [31:0] OutA, OutB, OutImm, OutPC;
  logic [4:0]  OutWn;
  logic [5:0]  OutOp, OutFunct;
  logic [15:0] StallCount;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage dut (
    .Clock(Clock), .Resetn(Resetn), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .InPC(InPC), .Flush(Flush), .Rn1(Rn1), .Rn2(Rn2),
    .Out1(Out1), .Out2(Out2), .WbWrite(WbWrite), .WbWn(WbWn), .WbWd(WbWd),
    .OutValid(OutValid), .ExReady(ExReady), .OutA(OutA), .OutB(OutB),
    .OutImm(OutImm), .OutWn(OutWn), .OutOp(OutOp), .OutFunct(OutFunct),
    .OutLoad(OutLoad), .OutIllegal(OutIllegal), .OutPC(OutPC),
    .StallCount(StallCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] out1;
    logic [31:0] out2;
    logic [31:0] wbwd;
    logic        wbwrite;
    logic [4:0]  wbwn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  wn;
    logic        load;
    logic        illegal;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    InValid = 1'b0; Flush = 1'b0; ExReady = 1'b1;
    Instr = 32'd0; InPC = 32'd0; Out1 = 32'd0; Out2 = 32'd0;
    WbWrite = 1'b0; WbWn = 5'd0; WbWd = 32'd0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},   {31'd0, OutValid},   32'd0);
    chk({tag, "_a"},       OutA,                32'd0);
    chk({tag, "_b"},       OutB,                32'd0);
    chk({tag, "_imm"},     OutImm,              32'd0);
    chk({tag, "_wn"},      {27'd0, OutWn},      32'd0);
    chk({tag, "_op"},      {26'd0, OutOp},      32'd0);
    chk({tag, "_funct"},   {26'd0, OutFunct},   32'd0);
    chk({tag, "_load"},    {31'd0, OutLoad},    32'd0);
    chk({tag, "_illegal"}, {31'd0, OutIllegal}, 32'd0);
    chk({tag, "_pc"},      OutPC,               32'd0);
    chk({tag, "_stall"},   {16'd0, StallCount}, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    Resetn = 1'b0;
    repeat (2) tick();
    Resetn = 1'b1;
    check_zero("reset");
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] pc;

    //           instr         out1          out2          wbwd        wbw  wbwn  a             b             imm           wn    ld    ill
    vecs[0]  = '{32'h20010005, 32'h0,        32'h77,       32'h0,      1'b0, 5'd0, 32'h0,        32'h77,       32'h5,        5'd1, 1'b0, 1'b0};
    vecs[1]  = '{32'h3402FFFF, 32'h99,       32'h22,       32'h0,      1'b0, 5'd0, 32'h0,        32'h22,       32'h0000FFFF, 5'd2, 1'b0, 1'b0};
    vecs[2]  = '{32'h2002FFFF, 32'h99,       32'h22,       32'h0,      1'b0, 5'd0, 32'h0,        32'h22,       32'hFFFFFFFF, 5'd2, 1'b0, 1'b0};
    vecs[3]  = '{32'h00642820, 32'hDEAD,     32'hBEEF,     32'h1234,   1'b1, 5'd3, 32'h1234,     32'hBEEF,     32'h00002820, 5'd5, 1'b0, 1'b0};
    vecs[4]  = '{32'h00642820, 32'hDEAD,     32'hBEEF,     32'h1234,   1'b1, 5'd0, 32'hDEAD,     32'hBEEF,     32'h00002820, 5'd5, 1'b0, 1'b0};
    vecs[5]  = '{32'h00042820, 32'hDEAD,     32'hBEEF,     32'h5678,   1'b1, 5'd4, 32'h0,        32'h5678,     32'h00002820, 5'd5, 1'b0, 1'b0};
    vecs[6]  = '{32'hFC221234, 32'h11,       32'h22,       32'h0,      1'b0, 5'd0, 32'h11,       32'h22,       32'h00001234, 5'd0, 1'b0, 1'b1};
    vecs[7]  = '{32'hACA4FFFC, 32'h55,       32'h44,       32'h0,      1'b0, 5'd0, 32'h55,       32'h44,       32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
    vecs[8]  = '{32'h8C440008, 32'h200,      32'h400,      32'h0,      1'b0, 5'd0, 32'h200,      32'h400,      32'h00000008, 5'd4, 1'b1, 1'b0};
    vecs[9]  = '{32'h30C78001, 32'h66,       32'h77,       32'hAAAA,   1'b1, 5'd5, 32'h66,       32'h77,       32'h00008001, 5'd7, 1'b0, 1'b0};
    vecs[10] = '{32'h1022FFFF, 32'h1,        32'h2,        32'h0,      1'b0, 5'd0, 32'h1,        32'h2,        32'hFFFFFFFF, 5'd0, 1'b0, 1'b0};
    vecs[11] = '{32'h25098000, 32'h88,       32'h99,       32'h0,      1'b0, 5'd0, 32'h88,       32'h99,       32'hFFFF8000, 5'd9, 1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      w  = vecs[i].instr;
      pc = 32'h1000 + 32'(i) * 4;
      InValid = 1'b1; ExReady = 1'b1; Flush = 1'b0;
      Instr = w; InPC = pc;
      Out1 = vecs[i].out1; Out2 = vecs[i].out2;
      WbWrite = vecs[i].wbwrite; WbWn = vecs[i].wbwn; WbWd = vecs[i].wbwd;
      #1;
      chk($sformatf("v%0d_rn1", i), {27'd0, Rn1}, {27'd0, w[25:21]});
      chk($sformatf("v%0d_rn2", i), {27'd0, Rn2}, {27'd0, w[20:16]});
      chk($sformatf("v%0d_inready", i), {31'd0, InReady}, 32'd1);
      tick();
      chk($sformatf("v%0d_valid", i),   {31'd0, OutValid},   32'd1);
      chk($sformatf("v%0d_a", i),       OutA,                vecs[i].a);
      chk($sformatf("v%0d_b", i),       OutB,                vecs[i].b);
      chk($sformatf("v%0d_imm", i),     OutImm,              vecs[i].imm);
      chk($sformatf("v%0d_wn", i),      {27'd0, OutWn},      {27'd0, vecs[i].wn});
      chk($sformatf("v%0d_op", i),      {26'd0, OutOp},      {26'd0, w[31:26]});
      chk($sformatf("v%0d_funct", i),   {26'd0, OutFunct},   {26'd0, w[5:0]});
      chk($sformatf("v%0d_load", i),    {31'd0, OutLoad},    {31'd0, vecs[i].load});
      chk($sformatf("v%0d_illegal", i), {31'd0, OutIllegal}, {31'd0, vecs[i].illegal});
      chk($sformatf("v%0d_pc", i),      OutPC,               pc);
      InValid = 1'b0;
      tick();
      chk($sformatf("v%0d_bubble", i), {31'd0, OutValid}, 32'd0);
    end

    // Load-use: lw $4,0($0) then add $5,$4,$4 stalls exactly one cycle.
    do_reset();
    InValid = 1'b1; Instr = 32'h8C040000; InPC = 32'h2000;
    tick();
    chk("lu_lw_valid", {31'd0, OutValid}, 32'd1);
    chk("lu_lw_load",  {31'd0, OutLoad},  32'd1);
    Instr = 32'h00842820; InPC = 32'h2004;
    #1;
    chk("lu_inready_stall", {31'd0, InReady}, 32'd0);
    tick();
    chk("lu_bubble",      {31'd0, OutValid},   32'd0);
    chk("lu_stallcount",  {16'd0, StallCount}, 32'd1);
    chk("lu_inready_ok",  {31'd0, InReady},    32'd1);
    tick();
    chk("lu_add_valid",   {31'd0, OutValid},   32'd1);
    chk("lu_add_wn",      {27'd0, OutWn},      32'd5);
    chk("lu_add_pc",      OutPC,               32'h2004);
    chk("lu_stall_final", {16'd0, StallCount}, 32'd1);

    // Hold for 3 cycles with execute stalled, then a flush drops the incoming one.
    ExReady = 1'b0; Instr = 32'h3402FFFF; InPC = 32'h2008;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_inready", c), {31'd0, InReady}, 32'd0);
      tick();
      chk($sformatf("hold%0d_valid", c), {31'd0, OutValid}, 32'd1);
      chk($sformatf("hold%0d_wn", c),    {27'd0, OutWn},    32'd5);
      chk($sformatf("hold%0d_pc", c),    OutPC,             32'h2004);
      chk($sformatf("hold%0d_imm", c),   OutImm,            32'h00002820);
    end
    Flush = 1'b1;
    tick();
    Flush = 1'b0; InValid = 1'b0; ExReady = 1'b1;
    chk("flush_valid", {31'd0, OutValid}, 32'd0);
    chk("flush_pc",    OutPC,             32'h2004);
    tick();
    chk("flush_stays_empty", {31'd0, OutValid}, 32'd0);

    // Flush together with a load-use hazard: flush wins, stall still counted.
    InValid = 1'b1; Instr = 32'h8C040000; InPC = 32'h3000;
    tick();
    chk("fh_lw_valid", {31'd0, OutValid}, 32'd1);
    Instr = 32'h00842820; InPC = 32'h3004; Flush = 1'b1;
    tick();
    Flush = 1'b0; InValid = 1'b0;
    chk("fh_valid", {31'd0, OutValid},   32'd0);
    chk("fh_stall", {16'd0, StallCount}, 32'd2);
    chk("fh_pc",    OutPC,               32'h3000);

    // Reset while an instruction is held discards it and clears the counter.
    InValid = 1'b1; Instr = 32'h20010005; InPC = 32'h4000;
    tick();
    chk("mr_valid", {31'd0, OutValid}, 32'd1);
    InValid = 1'b0; ExReady = 1'b0;
    tick();
    chk("mr_hold", {31'd0, OutValid}, 32'd1);
    Resetn = 1'b0;
    tick();
    check_zero("midreset");
    Resetn = 1'b1; ExReady = 1'b1; InValid = 1'b1;
    #1;
    chk("midreset_inready", {31'd0, InReady}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode / register-read stage sitting directly upstream of `RegFile`: it takes a fetched 32-bit MIPS instruction, drives `RegFile` read ports `Rn1`/`Rn2`, and captures the returned `Out1`/`Out2` plus decoded fields into the ID/EX pipeline register. It also bypasses same-cycle write-back data, detects load-use hazards (inserting one bubble), and handshakes with fetch and execute via valid/ready. A saturating counter of stall cycles is exposed for the performance-count test.

## Interface
- No parameters.
- `Clock` in 1: rising-edge clock.
- `Resetn` in 1: synchronous, active-low reset.
- `InValid` in 1: fetch presents a valid instruction.
- `InReady` out 1: stage accepts an instruction this cycle.
- `Instr` in 32: instruction word.
- `InPC` in 32: PC of `Instr`.
- `Flush` in 1: discard held and incoming instruction (branch redirect).
- `Rn1`, `Rn2` out 5: RegFile read addresses (combinational from `Instr`).
- `Out1`, `Out2` in 32: RegFile read data.
- `WbWrite` in 1, `WbWn` in 5, `WbWd` in 32: write-back port, same signals driven to RegFile `Write`/`Wn`/`Wd`.
- `OutValid` out 1: ID/EX register holds a valid instruction.
- `ExReady` in 1: execute consumes the held instruction.
- `OutA`, `OutB` out 32: operand values.
- `OutImm` out 32: extended immediate.
- `OutWn` out 5: destination register (0 = no write).
- `OutOp` out 6, `OutFunct` out 6: opcode and funct.
- `OutLoad` out 1: instruction is `lw`.
- `OutIllegal` out 1: unsupported opcode.
- `OutPC` out 32: PC of held instruction.
- `StallCount` out 16: load-use stall cycles, saturating.

## Operation
- `Rn1` = `Instr[25:21]` (rs), `Rn2` = `Instr[20:16]` (rt), always, regardless of `InValid`.
- Supported opcodes: 0x00 R-type, 0x08 addi, 0x09 addiu, 0x0C andi, 0x0D ori, 0x23 lw, 0x2B sw, 0x04 beq. Any other sets `OutIllegal`=1, `OutWn`=0.
- Destination: R-type -> rd `Instr[15:11]`; addi/addiu/andi/ori/lw -> rt; sw/beq -> 0.
- Immediate: andi/ori zero-extend `Instr[15:0]`; all others sign-extend. R-type `OutImm` = sign-extended value (don't-care downstream, but deterministic).
- Bypass: if `WbWrite` and `WbWn`!=0 and `WbWn`==rs, A-operand = `WbWd` else `Out1`; same for rt/B. Register 0 always reads as 0 regardless of `Out1`/`Out2`.
- Load-use hazard: `OutValid` & `OutLoad` & `OutWn`!=0 & (`OutWn`==rs, or `OutWn`==rt and instruction is R-type/sw/beq). Hazard is evaluated only when `InValid`=1.
- `InReady` = (~`OutValid` | `ExReady`) & ~hazard.
- Transfer when `InValid` & `InReady` & ~`Flush`: all Out* fields load, `OutValid`<=1.
- Bubble: if ~transfer & (`ExReady` | ~`OutValid`), `OutValid`<=0; data fields hold.
- Hold: `OutValid` & ~`ExReady` -> all outputs unchanged.
- `Flush`=1: `OutValid`<=0 next edge, incoming instruction dropped; `Flush` overrides all transfer and hold.
- `StallCount` increments on every edge where hazard=1 and `InValid`=1; saturates at 0xFFFF.

## Timing
- Latency 1 cycle: instruction accepted at edge N appears on Out* after edge N.
- `InReady`, `Rn1`, `Rn2` combinational; all other outputs registered.
- Load-use stall lasts exactly one cycle when `ExReady`=1 (the load leaves, the bubble enters, and hazard clears).
- Reset (`Resetn`=0 at edge): every registered output <= 0, including `StallCount`; reset mid-hold discards the held instruction. `InReady` after reset = 1 (for a non-hazard instruction).
- Simultaneous `Flush` and hazard: flush wins; `StallCount` still counts that cycle.

## Test plan
- Reset then addi $1,$0,5 (0x20010005), `Out1`=0: after one edge `OutValid`=1, `OutWn`=1, `OutImm`=5, `OutA`=0.
- `ori $2,$0,0xFFFF` -> `OutImm`=0x0000FFFF; `addi $2,$0,-1` -> `OutImm`=0xFFFFFFFF.
- `WbWrite`=1, `WbWn`=3, `WbWd`=0x1234, `Out1`=0xDEAD with rs=3 -> `OutA`=0x1234; same with `WbWn`=0 -> `OutA`=`Out1`; rs=0 -> `OutA`=0.
- `lw $4,0($0)` accepted, then `add $5,$4,$4` with `ExReady`=1 -> `InReady`=0 one cycle, bubble (`OutValid`=0), add accepted next cycle, `StallCount`=1.
- `ExReady`=0 for 3 cycles with valid held -> Out* unchanged, `InReady`=0; `Flush` pulse -> `OutValid`=0 next edge, incoming instruction dropped.
- Opcode 0x3F -> `OutIllegal`=1, `OutWn`=0; `Resetn`=0 mid-stream -> all outputs 0 after the edge.
